// File: rtl/pwm_ctrl_pkg.sv
// Shared constants for the PWM duty-register write controller.
package pwm_ctrl_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // Address byte layout: bit 7 selects auto-increment, bits 6:0 carry the channel
    localparam int         AUTOINC_BIT = 7;
    localparam logic [6:0] ADDR_MASK   = 7'h7F;

    function automatic logic [6:0] chan_addr(input logic [7:0] addr_byte);
        return addr_byte[6:0] & ADDR_MASK;
    endfunction

endpackage

// File: rtl/pwm_chan_index_counter.sv
// Channel index register: loads from the address byte, optionally steps
// after each write and wraps from the last channel back to 0.
module pwm_chan_index_counter
    import pwm_ctrl_pkg::*;
#(
    parameter int Channels = 8,
    parameter int IdxWidth = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [IdxWidth-1:0] load_val,
    input  logic                inc,
    output logic [IdxWidth-1:0] idx
);

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Channels - 1);

    // Load has priority; the load and increment never coincide in practice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (load) begin
            idx <= load_val;
        end else if (inc) begin
            idx <= (idx == LastIdx) ? '0 : idx + IdxWidth'(1);
        end
    end

endmodule

// File: rtl/pwm_reg_write_ctrl.sv
// Byte-stream to PWM duty-register write controller.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for the address byte of a frame
//   DATA  | channel selected, waiting for a data byte
//   LOAD  | one-cycle strobe: _HOLD[index] low, DataBus valid
//   ERR   | bad channel address; swallow bytes until the frame ends
module pwm_reg_write_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int Channels = 8,
    parameter int IdxWidth = 3
) (
    input  logic                CLK,
    input  logic                _RST,
    input  logic                _CS,
    input  logic                ByteValid,
    input  logic [7:0]          ByteIn,
    output logic                ByteReady,
    output logic [7:0]          DataBus,
    output logic [Channels-1:0] _HOLD,
    output logic                Error
);

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic                autoinc;
    logic                accept;
    logic [6:0]          addr;
    logic                addr_ok;
    logic                idx_load;
    logic                idx_inc;
    logic [IdxWidth-1:0] idx;

    // Ready is gated by reset too, so it drops the instant reset asserts
    always_comb begin
        ByteReady = _RST && !_CS && (state != ST_LOAD);
        accept    = ByteValid && ByteReady;
    end

    // Address byte decode
    always_comb begin
        addr     = chan_addr(ByteIn);
        addr_ok  = {1'b0, addr} < 8'(Channels);
        idx_load = accept && (state == ST_IDLE) && addr_ok;
        idx_inc  = (state == ST_LOAD) && autoinc;
    end

    pwm_chan_index_counter #(
        .Channels (Channels),
        .IdxWidth (IdxWidth)
    ) u_index (
        .clk      (CLK),
        .rst_n    (_RST),
        .load     (idx_load),
        .load_val (addr[IdxWidth-1:0]),
        .inc      (idx_inc),
        .idx      (idx)
    );

    // Next-state logic; deselect always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = addr_ok ? ST_DATA : ST_ERR;
            ST_DATA: if (accept) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_DATA;
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_IDLE;
        endcase
        if (_CS) begin
            state_nxt = ST_IDLE;
        end
    end

    // State register
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Auto-increment flag captured with the address byte
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            autoinc <= 1'b0;
        end else if (idx_load) begin
            autoinc <= ByteIn[AUTOINC_BIT];
        end
    end

    // Data byte holding register feeding every duty register
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            DataBus <= '0;
        end else if (accept && (state == ST_DATA)) begin
            DataBus <= ByteIn;
        end
    end

    // Error is re-evaluated on every selected IDLE edge: cleared at frame
    // start, or set when that edge takes an out-of-range address
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            Error <= 1'b0;
        end else if ((state == ST_IDLE) && !_CS) begin
            Error <= accept && !addr_ok;
        end
    end

    // Load enables decoded from registered state and index only
    always_comb begin
        _HOLD = '1;
        if (state == ST_LOAD) begin
            _HOLD[idx] = 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_reg_write_ctrl.sv
// Bench for pwm_reg_write_ctrl with 8 channels: directed frames, a
// frame-level reference model checked every cycle, and literal spot checks.
module tb_pwm_reg_write_ctrl;

    localparam int CH = 8;

    logic          clk;
    logic          rst_n;
    logic          cs_n;
    logic          byte_valid;
    logic [7:0]    byte_in;
    logic          byte_ready;
    logic [7:0]    data_bus;
    logic [CH-1:0] hold;
    logic          error;

    int n_cmp;
    int n_fail;

    // Duty registers loaded by the DUT, plus a log of every load
    logic [7:0] regs [CH];
    int         log_ch[$];
    logic [7:0] log_val[$];

    // Frame-level reference model
    bit         m_have_addr;
    bit         m_bad;
    bit         m_loading;
    bit         m_ainc;
    bit         m_err;
    int         m_chan;
    logic [7:0] m_data;

    pwm_reg_write_ctrl #(.Channels(CH), .IdxWidth(3)) dut (
        .CLK       (clk),
        ._RST      (rst_n),
        ._CS       (cs_n),
        .ByteValid (byte_valid),
        .ByteIn    (byte_in),
        .ByteReady (byte_ready),
        .DataBus   (data_bus),
        ._HOLD     (hold),
        .Error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_ready();
        return rst_n && !cs_n && !m_loading;
    endfunction

    function automatic logic [CH-1:0] model_hold();
        logic [CH-1:0] h;
        h = '1;
        if (m_loading) h[m_chan] = 1'b0;
        return h;
    endfunction

    // Model update: one step per edge, reset clears everything at once
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have_addr = 0; m_bad = 0; m_loading = 0; m_ainc = 0;
            m_err = 0; m_chan = 0; m_data = 8'h00;
        end else begin
            bit   acc;
            bit   idle;
            int   a;
            acc  = byte_valid && model_ready();
            idle = !m_have_addr && !m_bad && !m_loading;
            if (m_loading) begin
                m_loading = 0;
                if (m_ainc) m_chan = (m_chan + 1) % CH;
            end
            if (cs_n) begin
                m_have_addr = 0;
                m_bad       = 0;
            end else if (idle) begin
                m_err = 0;
                if (acc) begin
                    a = int'(byte_in & 8'h7F);
                    if (a < CH) begin
                        m_have_addr = 1;
                        m_chan      = a;
                        m_ainc      = byte_in[7];
                    end else begin
                        m_bad = 1;
                        m_err = 1;
                    end
                end
            end else if (m_have_addr && acc) begin
                m_data    = byte_in;
                m_loading = 1;
            end
        end
    end

    // Registers capture the shared bus on the edge ending a low _HOLD
    always @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (!hold[i]) begin
                regs[i] <= data_bus;
                log_ch.push_back(i);
                log_val.push_back(data_bus);
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        n_cmp++;
        if (hold !== model_hold() || data_bus !== m_data || error !== m_err ||
            byte_ready !== model_ready()) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t: got hold=%b bus=%h err=%b rdy=%b, want hold=%b bus=%h err=%b rdy=%b",
                     $time, hold, data_bus, error, byte_ready,
                     model_hold(), m_data, m_err, model_ready());
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a byte and keep it until an edge where ready was high
    task automatic send_byte(input logic [7:0] b);
        bit r;
        int budget;
        budget     = 20;
        byte_valid = 1'b1;
        byte_in    = b;
        do begin
            @(negedge clk);
            r = byte_ready;
            @(posedge clk);
            budget--;
        end while (!r && budget > 0);
        #1;
        byte_valid = 1'b0;
        if (!r) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: byte %h never accepted, want accepted within 20 cycles", b);
        end
    endtask

    task automatic end_frame();
        cycle(2);
        cs_n = 1'b1;
        cycle(2);
    endtask

    task automatic check_log(input string name, input int pos, input int ch, input logic [7:0] val);
        if (pos >= log_ch.size()) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: log has %0d entries, want entry %0d (ch%0d=%h)", name, log_ch.size(), pos, ch, val);
        end else begin
            check({name, "_ch"}, log_ch[pos], ch);
            check({name, "_val"}, {24'h0, log_val[pos]}, {24'h0, val});
        end
    endtask

    initial begin
        int mark;
        n_cmp = 0;
        n_fail = 0;
        for (int i = 0; i < CH; i++) regs[i] = 8'h00;
        rst_n      = 1'b0;
        cs_n       = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;

        #2;
        check("rst_hold", {24'h0, hold}, 32'hFF);
        check("rst_bus", {24'h0, data_bus}, 32'h00);
        check("rst_err", {31'h0, error}, 32'h0);
        check("rst_ready", {31'h0, byte_ready}, 32'h0);
        cycle(2);
        rst_n = 1'b1;
        cycle(1);

        // Single write to channel 3
        cs_n = 1'b0;
        send_byte(8'h03);
        send_byte(8'h5A);
        check("w3_hold", {24'h0, hold}, {24'h0, 8'b11110111});
        check("w3_bus", {24'h0, data_bus}, 32'h5A);
        check("w3_err", {31'h0, error}, 32'h0);
        check("w3_ready_load", {31'h0, byte_ready}, 32'h0);
        cycle(1);
        check("w3_hold_release", {24'h0, hold}, 32'hFF);
        check("w3_bus_keep", {24'h0, data_bus}, 32'h5A);
        end_frame();
        check("w3_reg", {24'h0, regs[3]}, 32'h5A);
        check("w3_nloads", log_ch.size(), 1);

        // Auto-increment burst wrapping 6 -> 7 -> 0
        mark = log_ch.size();
        cs_n = 1'b0;
        send_byte(8'h86);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        end_frame();
        check_log("ainc_0", mark, 6, 8'h11);
        check_log("ainc_1", mark + 1, 7, 8'h22);
        check_log("ainc_2", mark + 2, 0, 8'h33);
        check("ainc_nloads", log_ch.size() - mark, 3);

        // Bad address: error, no loads; next frame clears it
        mark = log_ch.size();
        cs_n = 1'b0;
        send_byte(8'h09);
        send_byte(8'hFF);
        check("bad_err", {31'h0, error}, 32'h1);
        check("bad_ready", {31'h0, byte_ready}, 32'h1);
        end_frame();
        check("bad_nloads", log_ch.size() - mark, 0);
        check("bad_err_sticky", {31'h0, error}, 32'h1);
        cs_n = 1'b0;
        send_byte(8'h01);
        check("bad_err_clear", {31'h0, error}, 32'h0);
        send_byte(8'h44);
        end_frame();
        check("bad_next_reg1", {24'h0, regs[1]}, 32'h44);
        check_log("bad_next", mark, 1, 8'h44);

        // Deselect in the same cycle as a data byte: dropped, back to IDLE
        mark = log_ch.size();
        cs_n = 1'b0;
        send_byte(8'h02);
        cs_n       = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h77;
        cycle(1);
        byte_valid = 1'b0;
        cycle(2);
        check("drop_nloads", log_ch.size() - mark, 0);
        check("drop_reg2", {24'h0, regs[2]}, 32'h00);
        // A following byte is taken as an address (0x66 is out of range)
        cs_n = 1'b0;
        send_byte(8'h66);
        check("drop_idle_addr", {31'h0, error}, 32'h1);
        end_frame();

        // Reset during LOAD aborts the write
        mark = log_ch.size();
        cs_n = 1'b0;
        send_byte(8'h02);
        send_byte(8'hAA);
        check("rl_hold_pre", {24'h0, hold}, {24'h0, 8'b11111011});
        rst_n = 1'b0;
        #1;
        check("rl_hold", {24'h0, hold}, 32'hFF);
        check("rl_bus", {24'h0, data_bus}, 32'h00);
        check("rl_ready", {31'h0, byte_ready}, 32'h0);
        check("rl_err", {31'h0, error}, 32'h0);
        cycle(1);
        cs_n  = 1'b1;
        rst_n = 1'b1;
        cycle(2);
        check("rl_nloads", log_ch.size() - mark, 0);
        check("rl_reg2", {24'h0, regs[2]}, 32'h00);

        // ByteValid held through LOAD, fixed channel
        mark = log_ch.size();
        cs_n = 1'b0;
        send_byte(8'h05);
        send_byte(8'h10);
        send_byte(8'h20);
        end_frame();
        check_log("hold_0", mark, 5, 8'h10);
        check_log("hold_1", mark + 1, 5, 8'h20);
        check("hold_nloads", log_ch.size() - mark, 2);
        check("hold_reg5", {24'h0, regs[5]}, 32'h20);
        check("final_reg0", {24'h0, regs[0]}, 32'h33);
        check("final_reg7", {24'h0, regs[7]}, 32'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
